// File: rtl/sc_pkg.sv
// Shared single-cycle CPU definitions: next-PC select encodings, fetch states
// and the default reset PC.
package sc_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/sc_npc.sv
// Next-PC selection for the fetch unit; purely combinational.
// Only inst[25:0] is needed: the branch immediate and the jump index.
module sc_npc
  import sc_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [25:0] inst,
  input  logic [31:0] ra,
  input  logic [1:0]  pcsource,
  output logic [31:0] npc,
  output logic        misalign
);

  logic signed [31:0] br_off;

  assign br_off = {{14{inst[15]}}, inst[15:0], 2'b00};

  always_comb begin
    npc      = pc4;
    misalign = 1'b0;
    case (pcsource)
      PC_BR: npc = pc4 + br_off;
      PC_JR: begin
        // Low bits are dropped so the PC stays word aligned; the caller is told.
        npc      = {ra[31:2], 2'b00};
        misalign = |ra[1:0];
      end
      PC_J:    npc = {pc4[31:28], inst[25:0], 2'b00};
      default: npc = pc4;
    endcase
  end

endmodule

// File: rtl/sc_ifetch.sv
// Instruction-fetch unit: PC register, ready-handshake fetch from instruction
// memory, and next-PC commit on the datapath's advance strobe.
module sc_ifetch
  import sc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [11:0] op,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic [1:0]  pcsource,
  input  logic [31:0] ra,
  input  logic        advance,
  output logic        misalign,
  output logic [31:0] instret
);

  fetch_state_t state_p0;
  logic [31:0]  npc;
  logic         npc_misalign;

  assign pc4       = pc + 32'd4;
  assign imem_addr = pc;
  assign op        = {inst[31:26], inst[5:0]};

  sc_npc u_npc (
    .pc4      (pc4),
    .inst     (inst[25:0]),
    .ra       (ra),
    .pcsource (pcsource),
    .npc      (npc),
    .misalign (npc_misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0   <= ST_IDLE;
      pc         <= RESET_PC;
      inst       <= 32'h0;
      imem_req   <= 1'b0;
      inst_valid <= 1'b0;
      misalign   <= 1'b0;
      instret    <= 32'h0;
    end else begin
      misalign <= 1'b0;
      case (state_p0)
        ST_IDLE: begin
          state_p0 <= ST_FETCH;
          imem_req <= 1'b1;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            inst       <= imem_rdata;
            state_p0   <= ST_ISSUE;
            imem_req   <= 1'b0;
            inst_valid <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (advance) begin
            pc         <= npc;
            instret    <= instret + 32'd1;
            misalign   <= npc_misalign;
            state_p0   <= ST_FETCH;
            imem_req   <= 1'b1;
            inst_valid <= 1'b0;
          end
        end
        default: begin
          state_p0   <= ST_IDLE;
          imem_req   <= 1'b0;
          inst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_ifetch.sv
// Bench for sc_ifetch: directed scenarios plus random handshakes, checked every
// cycle against a transaction-level model of the fetch unit.
module tb_sc_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [11:0] op;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [1:0]  pcsource;
  logic [31:0] ra;
  logic        advance;
  logic        misalign;
  logic [31:0] instret;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of what the unit must present after each edge.
  logic        m_started, m_req, m_valid, m_mis;
  logic [31:0] m_pc, m_inst, m_instret;

  always #5 clk = ~clk;

  sc_ifetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .op         (op),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc4        (pc4),
    .pcsource   (pcsource),
    .ra         (ra),
    .advance    (advance),
    .misalign   (misalign),
    .instret    (instret)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] target(input logic [1:0] ps, input logic [31:0] cur_pc,
                                         input logic [31:0] w, input logic [31:0] rav);
    logic [31:0] seq, off;
    seq = cur_pc + 32'd4;
    off = {{16{w[15]}}, w[15:0]} * 32'd4;
    case (ps)
      2'd1:    return seq + off;
      2'd2:    return rav & 32'hFFFF_FFFC;
      2'd3:    return (seq & 32'hF000_0000) | ({6'b0, w[25:0]} * 32'd4);
      default: return seq;
    endcase
  endfunction

  task automatic compare_all();
    chk("imem_req",   {31'b0, imem_req},   {31'b0, m_req});
    chk("imem_addr",  imem_addr,           m_pc);
    chk("inst",       inst,                m_inst);
    chk("op",         {20'b0, op},         {20'b0, m_inst[31:26], m_inst[5:0]});
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_valid});
    chk("pc",         pc,                  m_pc);
    chk("pc4",        pc4,                 m_pc + 32'd4);
    chk("misalign",   {31'b0, misalign},   {31'b0, m_mis});
    chk("instret",    instret,             m_instret);
  endtask

  // One clock: drive inputs at the falling edge, advance the model over the
  // rising edge, then compare 1 ns after it.
  task automatic cyc(input logic r, input logic rdy, input logic [31:0] rd,
                     input logic adv, input logic [1:0] ps, input logic [31:0] rav);
    @(negedge clk);
    rst = r; imem_ready = rdy; imem_rdata = rd; advance = adv; pcsource = ps; ra = rav;
    @(posedge clk);
    #1;
    if (r) begin
      m_started = 1'b0; m_req = 1'b0; m_valid = 1'b0; m_mis = 1'b0;
      m_pc = 32'h100; m_inst = 32'h0; m_instret = 32'h0;
    end else begin
      m_mis = 1'b0;
      if (!m_started) begin
        m_started = 1'b1;
        m_req = 1'b1;
      end else if (m_req && rdy) begin
        m_inst = rd; m_req = 1'b0; m_valid = 1'b1;
      end else if (m_valid && adv) begin
        m_mis = (ps == 2'd2) && (rav[1:0] != 2'b00);
        m_pc = target(ps, m_pc, m_inst, rav);
        m_instret = m_instret + 32'd1;
        m_valid = 1'b0; m_req = 1'b1;
      end
    end
    compare_all();
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, $urandom, 1'b0, 2'($urandom), $urandom);
  endtask

  task automatic fetch_word(input int nwait, input logic [31:0] w);
    repeat (nwait) idle_cyc();
    cyc(1'b0, 1'b1, w, 1'b0, 2'($urandom), $urandom);
  endtask

  task automatic commit(input logic [1:0] ps, input logic [31:0] rav);
    cyc(1'b0, 1'b0, $urandom, 1'b1, ps, rav);
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; advance = 1'b0;
    pcsource = 2'b00; ra = 32'h0;
    m_started = 1'b0; m_req = 1'b0; m_valid = 1'b0; m_mis = 1'b0;
    m_pc = 32'h100; m_inst = 32'h0; m_instret = 32'h0;

    // Reset values.
    cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 2'b10, 32'h5);
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
    chk("reset_pc", pc, 32'h100);
    chk("reset_req", {31'b0, imem_req}, 32'h0);
    chk("reset_inst", inst, 32'h0);
    chk("reset_instret", instret, 32'h0);

    // First fetch: request one cycle after release, ready after 3 waits.
    idle_cyc();
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h100);
    fetch_word(3, 32'h2008_0005);
    chk("first_op", {20'b0, op}, {20'b0, 12'b001000_000101});
    chk("first_pc4", pc4, 32'h104);
    chk("first_valid", {31'b0, inst_valid}, 32'h1);

    // Ready during ISSUE must not reload inst.
    cyc(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 2'b00, 32'h0);
    chk("ready_in_issue", inst, 32'h2008_0005);

    // jr to 0x200, then advance during FETCH must not move pc.
    commit(2'b10, 32'h0000_0200);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 2'b01, 32'h0);
    chk("advance_in_fetch", pc, 32'h200);
    for (int i = 0; i < 10; i++) begin
      idle_cyc();
      chk("held_req", {31'b0, imem_req}, 32'h1);
      chk("held_addr", imem_addr, 32'h200);
    end

    // Backward branch by one word.
    fetch_word(0, 32'h1000_FFFE);
    commit(2'b01, $urandom);
    chk("branch_back", imem_addr, 32'h1FC);

    // j from 0x3000_0010 with index 0x40.
    fetch_word(1, 32'h0000_0008);
    commit(2'b10, 32'h3000_0010);
    fetch_word(2, 32'h0800_0040);
    commit(2'b11, $urandom);
    chk("jump", imem_addr, 32'h3000_0100);

    // Misaligned jr.
    fetch_word(0, 32'h0000_0008);
    commit(2'b10, 32'h0000_1237);
    chk("jr_pc", pc, 32'h1234);
    chk("jr_mis_on", {31'b0, misalign}, 32'h1);
    idle_cyc();
    chk("jr_mis_off", {31'b0, misalign}, 32'h0);

    // PC and instret wrap together.
    fetch_word(0, 32'h0000_0008);
    commit(2'b10, 32'hFFFF_FFFC);
    fetch_word(1, 32'h0000_0000);
    @(negedge clk);
    force dut.instret = 32'hFFFF_FFFF;
    #1 release dut.instret;
    m_instret = 32'hFFFF_FFFF;
    commit(2'b00, $urandom);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_instret", instret, 32'h0);

    // Reset mid-fetch, late ready ignored.
    idle_cyc();
    cyc(1'b1, 1'b0, 32'h0, 1'b0, 2'b00, 32'h0);
    cyc(1'b0, 1'b1, 32'h1234_5678, 1'b0, 2'b00, 32'h0);
    chk("rst_mid_valid", {31'b0, inst_valid}, 32'h0);
    chk("rst_mid_inst", inst, 32'h0);
    chk("rst_mid_pc", pc, 32'h100);
    chk("rst_mid_instret", instret, 32'h0);

    // Random traffic including ignored handshakes and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), $urandom,
          ($urandom_range(0, 2) == 0), 2'($urandom), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
